int_to_float_cvt_seq: RTL

//   Multi-cycle integer-to-single-precision converter (FCVT.S.W / FCVT.S.WU).

---
 rtl/fp_cvt_pkg.sv | 25 ++
 rtl/fp32_round_inc.sv | 32 +++
 rtl/int_to_float_cvt_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fp_cvt_pkg.sv
// Definitions shared by the FP conversion units (int_to_float_cvt_seq, float_to_int_cvt):
// rounding-mode encodings, sequencer states and FP32 field geometry.
package fp_cvt_pkg;

  localparam int FP32_W        = 32;
  localparam int FP32_EXP_W    = 8;
  localparam int FP32_MAN_W    = 23;
  localparam int FP32_EXP_BIAS = 127;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } cvt_state_e;

endpackage

// File: rtl/fp32_round_inc.sv
// Round-increment decision for an FP32 mantissa, given sign, lsb, guard and sticky bits.
// Reserved rounding modes fall back to round-to-nearest-even.
module fp32_round_inc
  import fp_cvt_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       sticky,
  input  logic [2:0] rm,
  output logic       inc
);

  function automatic logic round_inc(input logic       s,
                                     input logic       l,
                                     input logic       g,
                                     input logic       st,
                                     input logic [2:0] mode);
    logic r;
    case (mode)
      RM_RTZ:  r = 1'b0;
      RM_RDN:  r = s & (g | st);
      RM_RUP:  r = ~s & (g | st);
      RM_RMM:  r = g;
      default: r = g & (st | l);
    endcase
    return r;
  endfunction

  assign inc = round_inc(sign, lsb, guard, sticky, rm);

endmodule

// File: rtl/int_to_float_cvt_seq.sv
// Sequential 32-bit integer to FP32 converter (FCVT.S.W / FCVT.S.WU): iterative
// left-normalisation of the magnitude, one rounding cycle, start/busy/done handshake.
module int_to_float_cvt_seq
  import fp_cvt_pkg::*;
#(
  parameter int NORM_STEP = 4,
  parameter int EXP_BIAS  = FP32_EXP_BIAS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_unsigned,
  input  logic [31:0] int_rs1,
  input  logic [2:0]  rm,
  output logic        busy,
  output logic        done,
  output logic [31:0] fp_rd,
  output logic        fflags_nx
);

  cvt_state_e state_q, state_d;

  logic                  accept;
  logic                  in_sign;
  logic signed [31:0]    rs1_s;
  logic [31:0]           in_mag;
  logic                  in_zero;

  logic                  sign_q;
  logic [31:0]           mag_q;
  logic [FP32_EXP_W-1:0] exp_q;
  logic [2:0]            rm_q;
  logic [31:0]           fp_rd_q;
  logic                  nx_q;

  logic                  top_zero;
  logic [FP32_MAN_W-1:0] mant;
  logic                  guard;
  logic                  sticky;
  logic                  inc;
  logic [FP32_MAN_W:0]   mant_sum;
  logic [FP32_EXP_W-1:0] exp_rnd;

  assign accept  = start & ((state_q == IDLE) | (state_q == DONE));
  assign rs1_s   = int_rs1;
  assign in_sign = ~is_unsigned & int_rs1[31];
  // Negating the most negative value wraps back to 0x80000000, which is the correct magnitude.
  assign in_mag  = in_sign ? -rs1_s : int_rs1;
  assign in_zero = (in_mag == 32'd0);

  assign top_zero = (mag_q[31 -: NORM_STEP] == '0);

  assign mant   = mag_q[30:8];
  assign guard  = mag_q[7];
  assign sticky = |mag_q[6:0];

  fp32_round_inc u_round_inc (
    .sign   (sign_q),
    .lsb    (mant[0]),
    .guard  (guard),
    .sticky (sticky),
    .rm     (rm_q),
    .inc    (inc)
  );

  // A carry out of the mantissa leaves the fraction at zero and bumps the exponent.
  assign mant_sum = {1'b0, mant} + {{FP32_MAN_W{1'b0}}, inc};
  assign exp_rnd  = exp_q + {{(FP32_EXP_W-1){1'b0}}, mant_sum[FP32_MAN_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = in_zero ? DONE : NORM;
      end
      NORM: begin
        if (mag_q[31]) state_d = ROUND;
      end
      ROUND: begin
        state_d = DONE;
      end
      DONE: begin
        if (accept) state_d = in_zero ? DONE : NORM;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      rm_q    <= '0;
      fp_rd_q <= '0;
      nx_q    <= 1'b0;
    end else if (accept) begin
      sign_q <= in_sign;
      mag_q  <= in_mag;
      exp_q  <= FP32_EXP_W'(EXP_BIAS + 31);
      rm_q   <= rm;
      if (in_zero) begin
        fp_rd_q <= {in_sign, 31'b0};
        nx_q    <= 1'b0;
      end
    end else if (state_q == NORM && !mag_q[31]) begin
      // Coarse shift while the whole top window is empty, then single steps to land exactly.
      if (top_zero) begin
        mag_q <= mag_q << NORM_STEP;
        exp_q <= exp_q - FP32_EXP_W'(NORM_STEP);
      end else begin
        mag_q <= mag_q << 1;
        exp_q <= exp_q - FP32_EXP_W'(1);
      end
    end else if (state_q == ROUND) begin
      fp_rd_q <= {sign_q, exp_rnd, mant_sum[FP32_MAN_W-1:0]};
      nx_q    <= guard | sticky;
    end
  end

  assign busy      = (state_q == NORM) | (state_q == ROUND);
  assign done      = (state_q == DONE);
  assign fp_rd     = fp_rd_q;
  assign fflags_nx = nx_q;

endmodule
